// File: rtl/fp_classify_pipe.sv
// fp_classify_pipe
//   Multi-lane, two-stage IEEE-754 operand classifier with valid/ready flow
//   control and saturating per-class statistics counters.
//
//   Ports:
//     clk, rst_n           clock, asynchronous active-low reset
//     in_valid / in_ready  input stream handshake
//     in_data              LANES packed operands, lane i = {sign, exp, man}
//     out_valid / out_ready output stream handshake
//     out_flags            per lane {sign, snan, qnan, inf, norm, sub, zero}
//     clr_cnt              synchronous clear of all counters
//     cnt_zero/sub/inf/nan saturating counts of lanes transferred per class
module fp_classify_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int LANES = 2,
   parameter int CNT_W = 16
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic [LANES*(1+EXP_W+MAN_W)-1:0]     in_data,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [LANES*7-1:0]                   out_flags,
   input  logic                                 clr_cnt,
   output logic [CNT_W-1:0]                     cnt_zero,
   output logic [CNT_W-1:0]                     cnt_sub,
   output logic [CNT_W-1:0]                     cnt_inf,
   output logic [CNT_W-1:0]                     cnt_nan
);

   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int SW = $clog2(LANES + 1);

   logic                 va;
   logic [LANES*W-1:0]   a_data;
   logic [LANES*7-1:0]   flags_next;
   logic                 b_load;
   logic                 a_adv;
   logic                 accept;
   logic                 xfer;

   logic                 sgn;
   logic [EXP_W-1:0]     ex;
   logic [MAN_W-1:0]     mn;
   logic [6:0]           f;

   logic [SW-1:0]        n_zero;
   logic [SW-1:0]        n_sub;
   logic [SW-1:0]        n_inf;
   logic [SW-1:0]        n_nan;

   // in_ready looks through to out_ready so a full pipe still sustains
   // one beat per cycle when the consumer is draining.
   assign b_load   = !out_valid || out_ready;
   assign a_adv    = va && b_load;
   assign in_ready = !va || a_adv;
   assign accept   = in_valid && in_ready;
   assign xfer     = out_valid && out_ready;

   always_comb begin
      flags_next = '0;
      sgn        = 1'b0;
      ex         = '0;
      mn         = '0;
      f          = '0;
      for (int i = 0; i < LANES; i++) begin
         sgn  = a_data[i*W + W - 1];
         ex   = a_data[i*W + MAN_W +: EXP_W];
         mn   = a_data[i*W +: MAN_W];
         f    = '0;
         f[6] = sgn;
         if (&ex) begin
            if (mn == '0)         f[3] = 1'b1;
            else if (mn[MAN_W-1]) f[4] = 1'b1;
            else                  f[5] = 1'b1;
         end else if (ex == '0) begin
            if (mn == '0) f[0] = 1'b1;
            else          f[1] = 1'b1;
         end else begin
            f[2] = 1'b1;
         end
         flags_next[i*7 +: 7] = f;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         va        <= 1'b0;
         a_data    <= '0;
         out_valid <= 1'b0;
         out_flags <= '0;
      end else begin
         if (accept) begin
            va     <= 1'b1;
            a_data <= in_data;
         end else if (a_adv) begin
            va     <= 1'b0;
         end
         if (b_load) begin
            out_valid <= va;
            // flags only reload with a real beat so they hold while idle
            if (va) out_flags <= flags_next;
         end
      end
   end

   // Classes are mutually exclusive per lane, so qnan|snan is the NaN count.
   always_comb begin
      n_zero = '0;
      n_sub  = '0;
      n_inf  = '0;
      n_nan  = '0;
      for (int i = 0; i < LANES; i++) begin
         n_zero = n_zero + SW'(out_flags[i*7 + 0]);
         n_sub  = n_sub  + SW'(out_flags[i*7 + 1]);
         n_inf  = n_inf  + SW'(out_flags[i*7 + 3]);
         n_nan  = n_nan  + SW'(out_flags[i*7 + 4] | out_flags[i*7 + 5]);
      end
   end

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c,
                                                 input logic [SW-1:0]    n);
      logic [CNT_W:0] s;
      s = {1'b0, c} + (CNT_W+1)'(n);
      return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_zero <= '0;
         cnt_sub  <= '0;
         cnt_inf  <= '0;
         cnt_nan  <= '0;
      end else if (clr_cnt) begin
         // clear takes priority over a same-cycle transfer
         cnt_zero <= '0;
         cnt_sub  <= '0;
         cnt_inf  <= '0;
         cnt_nan  <= '0;
      end else if (xfer) begin
         cnt_zero <= sat_add(cnt_zero, n_zero);
         cnt_sub  <= sat_add(cnt_sub,  n_sub);
         cnt_inf  <= sat_add(cnt_inf,  n_inf);
         cnt_nan  <= sat_add(cnt_nan,  n_nan);
      end
   end

endmodule

// File: doc/fp_classify_pipe.md
Name: fp_classify_pipe

Overview:
- Parametrised, multi-lane, pipelined IEEE-754 operand classifier for the floating-point datapath.
- Sits in front of the FP arithmetic units. Each lane flags zero, subnormal, normal, infinity, quiet NaN and signalling NaN, and passes the sign through.
- Uses a valid/ready stream with full backpressure.
- Keeps saturating per-class event counters for debug and statistics.

Parameters:
- EXP_W, 8, exponent field width in bits.
- MAN_W, 23, mantissa (fraction) field width in bits. Must be at least 2.
- LANES, 2, number of operands classified per beat.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept an input beat.
- in_data  input  LANES*(1+EXP_W+MAN_W)  packed operands. Lane i occupies bits [(i+1)*W-1 : i*W], where W=1+EXP_W+MAN_W, and each lane is laid out {sign, exp, man}.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts the output beat.
- out_flags  output  LANES*7  per-lane flags {sign, snan, qnan, inf, norm, sub, zero}; lane i occupies bits [i*7+6 : i*7].
- clr_cnt  input  1  synchronous clear of all counters.
- cnt_zero  output  CNT_W  count of zero lanes transferred.
- cnt_sub  output  CNT_W  count of subnormal lanes transferred.
- cnt_inf  output  CNT_W  count of infinity lanes transferred.
- cnt_nan  output  CNT_W  count of NaN lanes (quiet plus signalling) transferred.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All valid bits are 0 and all counters are 0.
  - out_flags is 0 and in_ready is 1.
  - Asserting reset mid-operation discards every beat in flight; no partial beat survives.
- Classification per lane, with E = exponent field and M = mantissa field:
  - E all ones and M==0: inf.
  - E all ones and M!=0: NaN. qnan if M[MAN_W-1]=1, otherwise snan.
  - E==0 and M==0: zero.
  - E==0 and M!=0: sub.
  - Anything else: norm.
  - Exactly one of {zero, sub, norm, inf, qnan, snan} is 1 per lane on every valid output.
  - sign equals bit W-1 of the lane, including for zero, inf and NaN.
- Pipeline has two stages:
  - Stage A registers the raw lane data.
  - Stage B registers the computed flags and drives out_flags and out_valid.
  - Latency is 2 cycles from an accepted input to out_valid, with no stalls.
- Stall and advance rules:
  - B loads when !vB or out_ready.
  - A advances into B when vA and (!vB or out_ready).
  - in_ready = !vA or (A advances this cycle). This is combinational from out_ready and gives full throughput of 1 beat/cycle.
  - An input is accepted when in_valid and in_ready; it then loads A.
  - An output transfers when out_valid and out_ready.
- Data stability: while out_valid and !out_ready, out_flags is held stable and no beat is lost or duplicated.
- out_flags holds its last value when out_valid is 0. Its value in that state is don't-care for checking.
- Counters:
  - On each output transfer, each counter adds the number of lanes of that class in the beat (0..LANES).
  - Counters saturate at 2^CNT_W-1 and never wrap.
  - cnt_nan counts qnan plus snan.
- Counter clear:
  - clr_cnt zeroes all counters at the next edge.
  - If clr_cnt and a transfer occur in the same cycle, the clear wins and that beat's counts are dropped.
  - clr_cnt does not affect the pipeline.

Test Plan:
- Single beat, LANES=2, lane0=32'h3F800000 and lane1=32'h80000000 -> two cycles later out_valid=1; lane0 norm=1, sign=0; lane1 zero=1, sign=1; cnt_zero=1, all other counters 0.
- Beats of {32'h7F800000, 32'hFF800000}, then {32'h7FC00000, 32'h7F800001}, then {32'h00000001, 32'h807FFFFF} with out_ready=1 -> flags in order:
  - beat 1: inf/sign0, inf/sign1.
  - beat 2: qnan, snan.
  - beat 3: sub, sub/sign1.
  - Final counts: cnt_inf=2, cnt_nan=2, cnt_sub=2.
- Continuous in_valid for 8 beats with out_ready=0 -> exactly 2 beats accepted and in_ready=0 thereafter. Releasing out_ready then gives 8 beats out in order, 1 per cycle, none duplicated, and out_flags stable throughout the stall.
- CNT_W=4, 10 beats of two NaN lanes -> cnt_nan saturates at 15. A pulse of clr_cnt coinciding with a NaN transfer -> cnt_nan=0 on the following cycle.
- rst_n dropped asynchronously with 2 beats in flight -> out_valid=0 and counters=0 immediately. After release, in_ready=1 and no stale beat emerges.
- EXP_W=5, MAN_W=10, LANES=4 (half precision): 16'h7C00, 16'h7E00, 16'h0001, 16'h3C00 -> inf, qnan, sub, norm respectively.
